itcm_loader: RTL

Boot-time program loader that writes the instruction TCM through its read/write port while holding the core in reset. It consumes a byte stream from an upstream byte source (UART receiver or debug bridge) over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words to consecutive ITCM word addresses from 0, verifies a checksum, and then releases the core. It sits beside the core: it drives the ITCM write side and the core's reset input, while the core's fetch side reads the loaded image.

---
 rtl/itcm_loader_pkg.sv | 24 ++
 rtl/itcm_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/itcm_loader_pkg.sv
// rtl/itcm_loader_pkg.sv - shared types and constants for the ITCM boot loader
package itcm_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0]  MAGIC_DEFAULT  = 8'hA5;
  localparam int unsigned ADDR_W_DEFAULT = 12;

  // Number of 32-bit words addressable by an ITCM of the given byte-address width
  function automatic int unsigned max_words(input int unsigned addr_w);
    return 32'd1 << (addr_w - 32'd2);
  endfunction

  localparam int unsigned MAX_WORDS = max_words(ADDR_W_DEFAULT);

endpackage

// File: rtl/itcm_loader.sv
// rtl/itcm_loader.sv - byte-stream frame loader that fills the ITCM and releases the core
module itcm_loader
  import itcm_loader_pkg::*;
#(
  parameter int         ADDR_W = 12,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              itcm_we,
  output logic [ADDR_W-1:0] itcm_addr,
  output logic [31:0]       itcm_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int         WORD_W  = ADDR_W - 2;
  localparam logic [16:0] MAX_LEN = 17'(max_words(ADDR_W));

  state_t            state, state_next;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word_idx;
  logic [23:0]       word_buf;

  logic        accept;
  logic        is_magic;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = rx_valid & rx_ready;
  assign is_magic  = (rx_data == MAGIC);
  assign len_full  = {rx_data, len[7:0]};
  assign last_word = ((16'(word_idx) + 16'd1) == len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    core_rst   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (accept && is_magic) state_next = S_LEN0;
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (len_full == 16'd0)               state_next = S_CSUM;
          else if ({1'b0, len_full} > MAX_LEN) state_next = S_ERROR;
          else                                 state_next = S_DATA;
        end
      end
      S_DATA: if (accept && byte_cnt == 2'd3 && last_word) state_next = S_CSUM;
      S_CSUM: if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERROR;
      default: state_next = S_IDLE;
    endcase
    if (state == S_DONE) begin
      core_rst = 1'b0;
      done     = 1'b1;
    end
    if (state == S_ERROR) error = 1'b1;
  end

  // Datapath: rx_ready goes high one edge after reset release and stays there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready   <= 1'b0;
      itcm_we    <= 1'b0;
      itcm_addr  <= '0;
      itcm_wdata <= '0;
      len        <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      word_buf   <= '0;
    end else begin
      rx_ready <= 1'b1;
      itcm_we  <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (is_magic) begin
              csum     <= '0;
              byte_cnt <= '0;
              word_idx <= '0;
            end
          end
          S_LEN0: begin
            len[7:0] <= rx_data;
            csum     <= csum ^ rx_data;
          end
          S_LEN1: begin
            len[15:8] <= rx_data;
            csum      <= csum ^ rx_data;
          end
          S_DATA: begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                itcm_we    <= 1'b1;
                itcm_addr  <= {word_idx, 2'b00};
                itcm_wdata <= {rx_data, word_buf};
                word_idx   <= word_idx + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
